// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch from a latency-variable
// instruction memory into a small FIFO that feeds the IF/ID register.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus_4
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   rsp_pc_r;
  logic [31:0]   instr_q_r [DEPTH];
  logic [31:0]   pc_q_r    [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_cnt_r;

  logic [CW:0]   used_s;
  logic          req_fire_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [31:0]   redirect_aligned_s;

  // Credits cover both buffered entries and live (non-dropped) in-flight requests,
  // so every accepted response is guaranteed a FIFO slot.
  assign used_s        = {1'b0, count_r} + {1'b0, outstanding_r} - {1'b0, drop_cnt_r};
  assign mem_req_valid = !rst && !redirect && (used_s < DEPTH_L);
  assign mem_req_addr  = fetch_pc_r;
  assign req_fire_s    = mem_req_valid && mem_req_ready;

  assign drop_s        = mem_rsp_valid && (drop_cnt_r != {CW{1'b0}});
  assign push_s        = mem_rsp_valid && !redirect && (drop_cnt_r == {CW{1'b0}});
  assign outstanding_nxt_s = outstanding_r + CW'(req_fire_s) - CW'(mem_rsp_valid);
  assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

  assign out_valid     = (count_r != {CW{1'b0}}) && !redirect;
  assign pop_s         = out_valid && out_ready;
  assign out_instr     = instr_q_r[rd_ptr_r];
  assign out_pc        = pc_q_r[rd_ptr_r];
  assign out_pc_plus_4 = out_pc + 32'd4;

  // Fetch/response PCs, credit counters and FIFO storage; redirect overrides all traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= {CW{1'b0}};
      drop_cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_q_r[i] <= 32'h0000_0000;
        pc_q_r[i]    <= 32'h0000_0000;
      end
    end else if (redirect) begin
      // Everything still in flight, including a response landing now, belongs to the old path.
      fetch_pc_r    <= redirect_aligned_s;
      rsp_pc_r      <= redirect_aligned_s;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= outstanding_nxt_s;
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      outstanding_r <= outstanding_nxt_s;
      if (drop_s) begin
        drop_cnt_r <= drop_cnt_r - CW'(1'b1);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
      if (push_s) begin
        instr_q_r[wr_ptr_r] <= mem_rsp_data;
        pc_q_r[wr_ptr_r]    <= rsp_pc_r;
        wr_ptr_r            <= wr_ptr_r + AW'(1'b1);
        rsp_pc_r            <= rsp_pc_r + 32'd4;
      end else begin
        wr_ptr_r <= wr_ptr_r;
        rsp_pc_r <= rsp_pc_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: a latency-programmable in-order memory for the
// main instance and a zero-wait memory for a second instance with a wrapping RESET_PC.
module tb_instr_prefetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus_4;

  logic        w_rst = 1'b1;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = 32'h0;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_pc_plus_4;

  int n_checks = 0;
  int n_fail   = 0;

  int          mem_lat = 1;
  int          mem_cyc = 0;
  int          acc_cnt = 0;
  logic [31:0] last_acc_addr = 32'h0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4)
  );

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .rst(w_rst),
    .mem_req_valid(w_req_valid), .mem_req_ready(1'b1), .mem_req_addr(w_req_addr),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .redirect(1'b0), .redirect_pc(32'h0000_0000),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_instr(w_out_instr),
    .out_pc(w_out_pc), .out_pc_plus_4(w_out_pc_plus_4)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // In-order memory: a request accepted in cycle k answers in cycle k + mem_lat.
  always @(posedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      mem_rsp_valid <= 1'b0;
      acc_cnt       <= 0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend_addr.push_back(mem_req_addr);
        pend_due.push_back(mem_cyc + mem_lat);
        acc_cnt       <= acc_cnt + 1;
        last_acc_addr <= mem_req_addr;
      end
      if (pend_due.size() > 0 && pend_due[0] <= mem_cyc + 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= imem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
    mem_cyc <= mem_cyc + 1;
  end

  always @(posedge clk) begin
    w_rsp_valid <= w_req_valid;
    w_rsp_data  <= imem_word(w_req_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_after_reset(input int lat, input logic rdy, input logic ord);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    mem_lat = lat; mem_req_ready = rdy; out_ready = ord;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset state, then zero-wait streaming
    start_after_reset(1, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("rst_req_valid", 32'(mem_req_valid), 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_out_pc", out_pc, 32'h0);
    check_eq("rst_out_instr", out_instr, 32'h0);
    check_eq("rst_req_addr", mem_req_addr, 32'h0);
    rst = 1'b0;
    #1;
    check_eq("t1_c0_req_valid", 32'(mem_req_valid), 32'h1);
    check_eq("t1_c0_out_valid", 32'(out_valid), 32'h0);
    next_cycle(); #1;
    check_eq("t1_c1_out_valid", 32'(out_valid), 32'h0);
    check_eq("t1_c1_req_addr", mem_req_addr, 32'h4);
    for (int k = 0; k < 6; k++) begin
      next_cycle(); #1;
      check_eq("t1_out_valid", 32'(out_valid), 32'h1);
      check_eq("t1_out_pc", out_pc, 32'(4 * k));
      check_eq("t1_out_instr", out_instr, 32'h1000_0000 + 32'(k));
      check_eq("t1_out_pc4", out_pc_plus_4, 32'(4 * k + 4));
    end

    // 2: decode stalled -> exactly DEPTH requests, then drain and resume
    start_after_reset(1, 1'b1, 1'b0);
    #1;
    for (int k = 0; k < 7; k++) next_cycle();
    #1;
    check_eq("t2_acc_cnt", 32'(acc_cnt), 32'd4);
    check_eq("t2_last_addr", last_acc_addr, 32'hC);
    check_eq("t2_req_valid_full", 32'(mem_req_valid), 32'h0);
    check_eq("t2_out_pc_head", out_pc, 32'h0);
    next_cycle();
    out_ready = 1'b1;
    #1;
    check_eq("t2_drain0_pc", out_pc, 32'h0);
    check_eq("t2_drain0_req_valid", 32'(mem_req_valid), 32'h0);
    for (int j = 1; j < 5; j++) begin
      next_cycle(); #1;
      check_eq("t2_drain_valid", 32'(out_valid), 32'h1);
      check_eq("t2_drain_pc", out_pc, 32'(4 * j));
      if (j == 1) begin
        check_eq("t2_resume_valid", 32'(mem_req_valid), 32'h1);
        check_eq("t2_resume_addr", mem_req_addr, 32'h10);
      end
    end

    // 3: latency 3, two in flight, redirect to 0x200
    start_after_reset(3, 1'b1, 1'b1);
    #1;
    next_cycle(); #1;
    check_eq("t3_c1_addr", mem_req_addr, 32'h4);
    next_cycle();
    mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    #1;
    check_eq("t3_redir_req_valid", 32'(mem_req_valid), 32'h0);
    check_eq("t3_redir_out_valid", 32'(out_valid), 32'h0);
    next_cycle();
    redirect = 1'b0; mem_req_ready = 1'b1;
    #1;
    check_eq("t3_new_req_valid", 32'(mem_req_valid), 32'h1);
    check_eq("t3_new_req_addr", mem_req_addr, 32'h200);
    for (int k = 3; k < 7; k++) begin
      check_eq("t3_drop_out_valid", 32'(out_valid), 32'h0);
      next_cycle(); #1;
    end
    check_eq("t3_out_valid", 32'(out_valid), 32'h1);
    check_eq("t3_out_pc", out_pc, 32'h200);
    check_eq("t3_out_pc4", out_pc_plus_4, 32'h204);
    check_eq("t3_out_instr", out_instr, 32'h1000_0080);

    // 4: redirect with credits exhausted, response and out_ready all in one cycle
    start_after_reset(1, 1'b1, 1'b0);
    #1;
    for (int k = 0; k < 3; k++) next_cycle();
    next_cycle();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
    #1;
    check_eq("t4_rsp_present", 32'(mem_rsp_valid), 32'h1);
    check_eq("t4_redir_out_valid", 32'(out_valid), 32'h0);
    check_eq("t4_redir_req_valid", 32'(mem_req_valid), 32'h0);
    next_cycle();
    redirect = 1'b0;
    #1;
    check_eq("t4_empty_out_valid", 32'(out_valid), 32'h0);
    check_eq("t4_req_valid", 32'(mem_req_valid), 32'h1);
    check_eq("t4_req_addr", mem_req_addr, 32'h100);
    next_cycle(); #1;
    check_eq("t4_c6_out_valid", 32'(out_valid), 32'h0);
    next_cycle(); #1;
    check_eq("t4_out_valid", 32'(out_valid), 32'h1);
    check_eq("t4_out_pc", out_pc, 32'h100);
    check_eq("t4_out_instr", out_instr, 32'h1000_0040);

    // 5: memory stalls 5 cycles, redirect withdraws the pending request
    start_after_reset(1, 1'b0, 1'b1);
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq("t5_stall_valid", 32'(mem_req_valid), 32'h1);
      check_eq("t5_stall_addr", mem_req_addr, 32'h0);
      if (k < 4) begin
        next_cycle(); #1;
      end
    end
    next_cycle();
    redirect = 1'b1; redirect_pc = 32'h340;
    #1;
    check_eq("t5_withdrawn", 32'(mem_req_valid), 32'h0);
    next_cycle();
    redirect = 1'b0; mem_req_ready = 1'b1;
    #1;
    check_eq("t5_no_accept", 32'(acc_cnt), 32'd0);
    check_eq("t5_new_valid", 32'(mem_req_valid), 32'h1);
    check_eq("t5_new_addr", mem_req_addr, 32'h340);
    next_cycle(); next_cycle(); #1;
    check_eq("t5_out_pc", out_pc, 32'h340);

    // 6: wrapping RESET_PC, then reset mid-stream
    next_cycle(); #1;
    check_eq("t6_rst_req_valid", 32'(w_req_valid), 32'h0);
    check_eq("t6_rst_addr", w_req_addr, 32'hFFFF_FFF8);
    w_rst = 1'b0;
    #1;
    next_cycle(); #1;
    check_eq("t6_c1_out_valid", 32'(w_out_valid), 32'h0);
    next_cycle(); #1;
    check_eq("t6_pc0", w_out_pc, 32'hFFFF_FFF8);
    check_eq("t6_instr0", w_out_instr, 32'h4FFF_FFFE);
    next_cycle(); #1;
    check_eq("t6_pc1", w_out_pc, 32'hFFFF_FFFC);
    check_eq("t6_pc1_plus4", w_out_pc_plus_4, 32'h0);
    check_eq("t6_instr1", w_out_instr, 32'h4FFF_FFFF);
    next_cycle(); #1;
    check_eq("t6_pc2", w_out_pc, 32'h0);
    check_eq("t6_instr2", w_out_instr, 32'h1000_0000);
    next_cycle();
    w_rst = 1'b1;
    #1;
    next_cycle();
    w_rst = 1'b0;
    #1;
    check_eq("t6_post_rst_out_valid", 32'(w_out_valid), 32'h0);
    check_eq("t6_post_rst_req_valid", 32'(w_req_valid), 32'h1);
    check_eq("t6_post_rst_addr", w_req_addr, 32'hFFFF_FFF8);
    next_cycle(); next_cycle(); #1;
    check_eq("t6_restart_pc", w_out_pc, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
